// File: rtl/ls_pkg.sv
// Shared definitions for the load/store sequencer: FSM states, op encodings
// and default address/data widths.
package ls_pkg;

    localparam int unsigned LS_AW = 4;
    localparam int unsigned LS_DW = 4;

    localparam logic LS_LOAD  = 1'b0;
    localparam logic LS_STORE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WR,
        RD,
        WB
    } ls_state_e;

endpackage

// File: rtl/ls_ctrl.sv
// Load/store sequencer: takes one command through a valid/ready handshake, fetches
// address/data from the register file, strobes the RAM and writes load results back.
module ls_ctrl
    import ls_pkg::*;
#(
    parameter int unsigned AW = LS_AW,
    parameter int unsigned DW = LS_DW,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [AW-1:0] cmd_rd,
    output logic [AW-1:0] rf_addr_a,
    output logic [AW-1:0] rf_addr_b,
    input  logic [DW-1:0] rf_data_a,
    input  logic [DW-1:0] rf_data_b,
    output logic          rf_we,
    output logic [AW-1:0] rf_wt_addr,
    output logic [DW-1:0] rf_wt_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_wrt,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] done_cnt
);

    ls_state_e     state_q, state_d;
    logic          op_q, op_d;
    logic [AW-1:0] ra_q, ra_d;
    logic [AW-1:0] rb_q, rb_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [CW-1:0] done_cnt_q, done_cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            ra_q        <= '0;
            rb_q        <= '0;
            rd_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            rd_q        <= rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        rd_d        = rd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cmd_ready   = 1'b0;
        rf_addr_a   = '0;
        rf_addr_b   = '0;
        rf_we       = 1'b0;
        rf_wt_addr  = '0;
        rf_wt_data  = '0;
        mem_wrt     = 1'b0;
        mem_rd      = 1'b0;
        done        = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    ra_d    = cmd_ra;
                    rb_d    = cmd_rb;
                    rd_d    = cmd_rd;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rf_addr_a   = ra_q;
                rf_addr_b   = rb_q;
                mem_addr_d  = AW'(rf_data_a);
                mem_wdata_d = rf_data_b;
                state_d     = (op_q == LS_STORE) ? WR : RD;
            end
            WR: begin
                mem_wrt = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            RD: begin
                mem_rd  = 1'b1;
                state_d = WB;
            end
            WB: begin
                // R0 is hard-wired zero, so a load targeting it completes without writing.
                rf_we      = (rd_q != '0);
                rf_wt_addr = rd_q;
                rf_wt_data = mem_rdata;
                done       = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        done_cnt_d = done ? done_cnt_q + CW'(1) : done_cnt_q;
    end

    assign busy      = (state_q != IDLE);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: doc/ls_ctrl.md
Name: ls_ctrl

Overview:
Load/store sequencer sitting directly upstream of the register-file/RAM pair. It accepts one load or store command at a time and reads the address and store data from the register file. It then drives the 16x4 RAM write or read strobes and, for loads, writes the RAM result back into the register file. It replaces the hand-driven wrt/rd/L_S stimulus with a clean valid/ready front end.

Parameters:
AW, 4, RAM address width and register-file index width
DW, 4, data width of registers and RAM words
CW, 8, width of the completed-command counter

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command; high only in IDLE
cmd_op  in  1  0 = load, 1 = store
cmd_ra  in  AW  register index holding the RAM address
cmd_rb  in  AW  register index holding the store data (ignored for load)
cmd_rd  in  AW  destination register index for load (ignored for store)
rf_addr_a  out  AW  register-file read port A index
rf_addr_b  out  AW  register-file read port B index
rf_data_a  in  DW  register-file read data A (combinational)
rf_data_b  in  DW  register-file read data B (combinational)
rf_we  out  1  register-file write enable (the register file's L_S input)
rf_wt_addr  out  AW  register-file write index
rf_wt_data  out  DW  register-file write data
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_wrt  out  1  RAM write strobe
mem_rd  out  1  RAM read strobe; data registered by RAM on the same edge
mem_rdata  in  DW  RAM read data, valid the cycle after mem_rd
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on command completion
done_cnt  out  CW  count of completed commands

Behaviour:
- Reset (async, any time): state goes to IDLE, and the captured command, address and data registers clear to 0. All outputs are 0 except cmd_ready=1. done_cnt is 0. An in-flight command is dropped with no done pulse; the RAM and register-file contents are left untouched.
- States: IDLE, FETCH, WR, RD, WB.
- IDLE: cmd_ready=1. When cmd_valid is high at an edge, capture op/ra/rb/rd and go to FETCH. When cmd_valid is low, stay in IDLE.
- FETCH: rf_addr_a=ra and rf_addr_b=rb. At the edge, latch mem_addr<=rf_data_a and mem_wdata<=rf_data_b. Go to WR if op=store, else RD.
- WR: mem_wrt=1 for exactly one cycle; done=1 in this cycle. Go to IDLE.
- RD: mem_rd=1 for exactly one cycle. Go to WB.
- WB: rf_wt_addr=rd, rf_wt_data=mem_rdata, and rf_we=1 only if rd!=0. done=1 in this cycle. Go to IDLE.
- rf_addr_a and rf_addr_b are 0 outside FETCH. mem_wrt, mem_rd and rf_we are never high simultaneously.
- Latency from the accept edge: store done at the 2nd cycle after accept (3 cycles total); load done at the 3rd cycle after accept (4 cycles total). Back-to-back throughput: one command per latency+1 cycles.
- cmd_valid while busy: ignored; the command is not captured, and the upstream must hold it until cmd_ready.
- Register index 0 as ra or rb reads the value 0, so address 0 or data 0 is used.
- Load with rd=0: RAM is still read and done still pulses, but there is no register write.
- done_cnt increments on each done pulse and wraps from 2^CW-1 to 0.
- Outputs mem_addr and mem_wdata hold their last latched value until the next FETCH.

Decomposition:
- Shared package ls_pkg holds: the state enum (IDLE, FETCH, WR, RD, WB), the op constants LS_LOAD=0 and LS_STORE=1, and the AW/DW defaults.
- Single flat module; no natural sub-module. A bench top wires ls_ctrl to the existing register file and RAM.

Test Plan:
- Reset then idle: assert rst for 10 ns, cmd_valid=0 -> cmd_ready=1, busy=0, all strobes 0, done_cnt=0.
- Store: preload R3=4'h7 and R5=4'h4; issue store ra=3, rb=5 -> mem_wrt pulses with mem_addr=7 and mem_wdata=4; done 2 cycles after accept; RAM[7]=4.
- Load: after the store, issue load ra=3, rd=9 -> mem_rd pulses with addr 7; next cycle rf_we=1, rf_wt_addr=9, rf_wt_data=4; R9 reads 4; done_cnt=2.
- Load to R0: load ra=3, rd=0 -> mem_rd pulses, rf_we stays 0, done pulses, R0 still reads 0.
- Busy rejection: hold cmd_valid=1 with a store for 6 cycles -> accepted once per IDLE visit; no capture while busy; cmd_ready low in FETCH/WR.
- Reset mid-load: assert rst during RD -> immediate IDLE, no rf_we, no done, done_cnt=0; the next command executes normally.
